// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Upstream select sequencer for an 8:1 mux. Each scan steps the channel
//   selects {sel3,sel2,sel1} through channels 0..7, holds every channel for
//   SETTLE_CYCLES cycles, samples mux_out for one cycle, and assembles the
//   eight samples into data_out (bit k = channel k). A completed scan gives a
//   one-cycle valid pulse, plus a changed pulse when the word differs from the
//   previous one.
//
//   SETTLE_CYCLES : cycles a channel is held before it is sampled (legal 1..15).
//
//   Optional feature macro: MUX_SCAN_CONTINUOUS_EN
//     defined     - if start is high at the channel-7 sample, the next scan
//                   begins immediately with busy held high (back-to-back scans).
//     not defined - the sequencer always returns to IDLE after channel 7.
//
//   All outputs are registered. Reset is synchronous and active high, and it
//   overrides every other input, including an in-flight scan.

module mux_scan_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_out,
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       changed,
    output logic       busy
);

    // FSM encoding, kept as plain constants for legacy tool flows.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    localparam logic [2:0] LAST_CH     = 3'd7;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state_q,   state_d;
    logic [2:0] ch_q,      ch_d;
    logic [3:0] cnt_q,     cnt_d;
    logic [2:0] sel_q,     sel_d;
    logic [7:0] shadow_q,  shadow_d;
    logic [7:0] data_q,    data_d;
    logic       valid_q,   valid_d;
    logic       changed_q, changed_d;
    logic       busy_q,    busy_d;

    // Continuous-restart request. It is tied low when the feature is
    // compiled out, so the FSM has a single code path in both builds.
    logic       restart;

`ifdef MUX_SCAN_CONTINUOUS_EN
    assign restart = start;
`else
    assign restart = 1'b0;
`endif

    // Next-state logic for the scan FSM and every datapath register.
    always_comb begin
        // NOTE: every variable gets a default value before the case statement,
        // so any path that leaves one unassigned holds the register value
        // instead of inferring a latch.
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    ch_d    = 3'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                end
            end

            ST_SETTLE: begin
                // cnt counts the cycles already spent on this channel. The
                // last settle cycle moves to SAMPLE, so a channel is held
                // SETTLE_CYCLES cycles and then sampled for one more.
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                shadow_d[ch_q] = mux_out;
                if (ch_q != LAST_CH) begin
                    ch_d    = ch_q + 3'd1;
                    cnt_d   = 4'd0;
                    state_d = ST_SETTLE;
                end else begin
                    // Channel 7 goes straight into the output word. The
                    // shadow register has not captured it yet at this point.
                    data_d    = {mux_out, shadow_q[6:0]};
                    valid_d   = 1'b1;
                    changed_d = (data_d != data_q);
                    if (restart) begin
                        state_d = ST_SETTLE;
                        ch_d    = 3'd0;
                        cnt_d   = 4'd0;
                        busy_d  = 1'b1;
                    end else begin
                        // ch stays at 7 in IDLE. It wraps to 0 only when a
                        // new scan starts, and the select outputs are forced
                        // to 0 in IDLE anyway.
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // The selects follow the channel of the state being entered, so the
        // registered sel outputs line up with the state they belong to.
        sel_d = (state_d == ST_IDLE) ? 3'd0 : ch_d;
    end

    // State and output registers with synchronous, active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values from before the edge and the order of
        // the statements does not matter.
        if (rst) begin
            state_q   <= ST_IDLE;
            ch_q      <= 3'd0;
            cnt_q     <= 4'd0;
            sel_q     <= 3'd0;
            // NOTE: the shadow word is reset like the other registers. It is
            // only eight flops, and resetting it keeps every bit of
            // data_out/changed deterministic even if a channel was skipped
            // by an aborted scan.
            shadow_q  <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
        end
    end

    assign sel1     = sel_q[0];
    assign sel2     = sel_q[1];
    assign sel3     = sel_q[2];
    assign data_out = data_q;
    assign valid    = valid_q;
    assign changed  = changed_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (SETTLE_CYCLES = 1 and 3), each
// driving a behavioural 8:1 mux. Expected scan results are queued when a scan
// is launched. A negedge monitor pops an entry whenever valid is seen and
// compares the data, changed, busy and cycle of arrival.

module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance 0: default SETTLE_CYCLES (1)
    logic       start0 = 1'b0;
    logic       mux0;
    logic       s1_0, s2_0, s3_0;
    logic [7:0] data0;
    logic       valid0, chg0, busy0;
    logic [7:0] vec0 = 8'h00;

    // Instance 3: SETTLE_CYCLES = 3
    logic       start3 = 1'b0;
    logic       mux3;
    logic       s1_3, s2_3, s3_3;
    logic [7:0] data3;
    logic       valid3, chg3, busy3;
    logic [7:0] vec3 = 8'h00;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [31:0] at;
        logic [7:0]  data;
        logic        chg;
        logic        bsy;
    } exp_t;

    exp_t       q0[$];
    exp_t       q3[$];
    logic [7:0] prev0 = 8'h00;
    logic [7:0] prev3 = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 8:1 muxes driven by the select outputs
    assign mux0 = vec0[{s3_0, s2_0, s1_0}];
    assign mux3 = vec3[{s3_3, s2_3, s1_3}];

    mux_scan_sequencer u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .mux_out(mux0),
        .sel1(s1_0), .sel2(s2_0), .sel3(s3_0),
        .data_out(data0), .valid(valid0), .changed(chg0), .busy(busy0)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .mux_out(mux3),
        .sel1(s1_3), .sel2(s2_3), .sel3(s3_3),
        .data_out(data3), .valid(valid3), .changed(chg3), .busy(busy3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_valid(input string tag, input exp_t e, input logic [7:0] d,
                             input logic c, input logic b);
        check({tag, "_valid_cycle"}, cyc, e.at);
        check({tag, "_data_out"}, {24'h0, d}, {24'h0, e.data});
        check({tag, "_changed"}, {31'h0, c}, {31'h0, e.chg});
        check({tag, "_busy_at_valid"}, {31'h0, b}, {31'h0, e.bsy});
    endtask

    // Queue an expected scan result. changed is derived from the previously
    // expected word of the same instance.
    task automatic push(input int id, input int at, input logic [7:0] d, input logic b);
        exp_t e;
        e.at   = at;
        e.data = d;
        e.bsy  = b;
        if (id == 0) begin
            e.chg = (d != prev0);
            prev0 = d;
            q0.push_back(e);
        end else begin
            e.chg = (d != prev3);
            prev3 = d;
            q3.push_back(e);
        end
    endtask

    // Monitor: pops and compares on every valid pulse
    always @(negedge clk) begin
        exp_t e;
        if (valid0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_valid data_out=%0h expected no valid (cycle %0d)", data0, cyc);
            end else begin
                e = q0.pop_front();
                cmp_valid("dut0", e, data0, chg0, busy0);
            end
        end
        if (chg0 && !valid0) begin
            checks++; errors++;
            $display("FAIL dut0_changed_without_valid actual=1 expected=0 (cycle %0d)", cyc);
        end
        if (valid3) begin
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut3_unexpected_valid data_out=%0h expected no valid (cycle %0d)", data3, cyc);
            end else begin
                e = q3.pop_front();
                cmp_valid("dut3", e, data3, chg3, busy3);
            end
        end
        if (chg3 && !valid3) begin
            checks++; errors++;
            $display("FAIL dut3_changed_without_valid actual=1 expected=0 (cycle %0d)", cyc);
        end
    end

    // Hold reset for n cycles, then check both instances are fully reset.
    task automatic apply_reset(input int n, input logic start_val);
        @(negedge clk);
        rst    = 1'b1;
        start0 = start_val;
        start3 = start_val;
        q0.delete();
        q3.delete();
        repeat (n) @(negedge clk);
        rst    = 1'b0;
        start0 = 1'b0;
        start3 = 1'b0;
        prev0  = 8'h00;
        prev3  = 8'h00;
        check("rst_sel0",     {29'h0, s3_0, s2_0, s1_0}, 32'h0);
        check("rst_data0",    {24'h0, data0}, 32'h0);
        check("rst_valid0",   {31'h0, valid0}, 32'h0);
        check("rst_changed0", {31'h0, chg0}, 32'h0);
        check("rst_busy0",    {31'h0, busy0}, 32'h0);
        check("rst_sel3",     {29'h0, s3_3, s2_3, s1_3}, 32'h0);
        check("rst_data3",    {24'h0, data3}, 32'h0);
        check("rst_busy3",    {31'h0, busy3}, 32'h0);
    endtask

    // One-cycle start pulse. Returns the cycle count of the start edge,
    // sampled at the negedge just after it.
    task automatic pulse_start(input int id, output int n0);
        @(negedge clk);
        if (id == 0) start0 = 1'b1;
        else         start3 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start3 = 1'b0;
        n0 = cyc;
    endtask

    // Called at the negedge after the start edge. Checks that each channel
    // is held s+1 cycles with busy high, and that the selects return to 0.
    task automatic check_sel_steps(input int id, input int s);
        for (int j = 0; j < 8 * (s + 1); j++) begin
            if (j > 0) @(negedge clk);
            if (id == 0) begin
                check("sel_step0", {29'h0, s3_0, s2_0, s1_0}, j / (s + 1));
                check("busy_scan0", {31'h0, busy0}, 32'h1);
            end else begin
                check("sel_step3", {29'h0, s3_3, s2_3, s1_3}, j / (s + 1));
                check("busy_scan3", {31'h0, busy3}, 32'h1);
            end
        end
        @(negedge clk);
        if (id == 0) check("sel_idle0", {29'h0, s3_0, s2_0, s1_0}, 32'h0);
        else         check("sel_idle3", {29'h0, s3_3, s2_3, s1_3}, 32'h0);
    endtask

    initial begin
        int  n0;
        bit  got;

        // 1: reset held two cycles with start high
        apply_reset(2, 1'b1);

        // 2: basic scan, A5, default settle
        vec0 = 8'hA5;
        pulse_start(0, n0);
        push(0, n0 + 16, 8'hA5, 1'b0);
        check_sel_steps(0, 1);
        repeat (4) @(negedge clk);

        // 3: extra start pulses at cycles 3 and 9 are ignored
        vec0 = 8'h96;
        pulse_start(0, n0);
        push(0, n0 + 16, 8'h96, 1'b0);
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (14) @(negedge clk);

        // 4: reset mid-scan aborts it, then a full scan follows
        vec0 = 8'h5A;
        pulse_start(0, n0);
        repeat (7) @(negedge clk);
        apply_reset(1, 1'b0);
        repeat (20) @(negedge clk);
        pulse_start(0, n0);
        push(0, n0 + 16, 8'h5A, 1'b0);
        repeat (20) @(negedge clk);

        // 5: SETTLE_CYCLES = 3, 3C twice (second gives changed = 0)
        vec3 = 8'h3C;
        pulse_start(3, n0);
        push(3, n0 + 32, 8'h3C, 1'b0);
        check_sel_steps(3, 3);
        repeat (4) @(negedge clk);
        pulse_start(3, n0);
        push(3, n0 + 32, 8'h3C, 1'b0);
        repeat (36) @(negedge clk);

        // 6: start held high, data switches to 3C after the first valid
        apply_reset(2, 1'b0);
        vec0 = 8'hA5;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        n0 = cyc;
`ifdef MUX_SCAN_CONTINUOUS_EN
        push(0, n0 + 16, 8'hA5, 1'b1);
        push(0, n0 + 32, 8'h3C, 1'b0);
`else
        push(0, n0 + 16, 8'hA5, 1'b0);
        push(0, n0 + 33, 8'h3C, 1'b0);
`endif
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (valid0) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL hold_start_first_valid_timeout actual=none expected=valid within 40 cycles");
        end
        vec0 = 8'h3C;
        while (cyc < n0 + 20) @(negedge clk);
        start0 = 1'b0;
        repeat (24) @(negedge clk);

        check("sb0_drained", q0.size(), 32'h0);
        check("sb3_drained", q3.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: every wait above is bounded, so this only fires if the bench
    // itself stops advancing.
    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
